// File: rtl/perceptron_train_sequencer.sv
// perceptron_train_sequencer
//
// Trains a perceptron over a small on-chip sample set. One shared signed
// multiplier feeds an accumulator at one product per cycle. Each sample
// goes through MAC (dot product), ACT (step activation and error) and UPD
// (weight update). Epochs repeat until an epoch has no errors or until
// MAX_EPOCHS epochs have run.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               global enable; when low, every flop holds its value
//   load_valid/ready  word stream; a word is taken when valid & ready
//   load_data         load word: W[0..DIM-1], then X[s][0..DIM-1], Y[s] per sample
//   load_restart      rewind the load pointer (only in IDLE/DONE)
//   start             start pulse; accepted in IDLE/DONE once the set is loaded
//   busy, done        training in progress / finished (level)
//   converged         the last epoch had zero errors
//   epoch_cnt         epochs completed in the current or last run
//   err_cnt           misclassifications in the last completed epoch
//   w_sel, w_out      combinational weight readback
module perceptron_train_sequencer #(
  parameter int N_SAMPLES  = 3,
  parameter int DIM        = 2,
  parameter int DW         = 8,
  parameter int MAX_EPOCHS = 15,
  localparam int SEL_W     = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [DW-1:0]    load_data,
  input  logic             load_restart,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic [7:0]       epoch_cnt,
  output logic [7:0]       err_cnt,
  input  logic [SEL_W-1:0] w_sel,
  output logic [DW-1:0]    w_out
);

  localparam int TOTAL = DIM + N_SAMPLES * (DIM + 1);
  localparam int PTR_W = $clog2(TOTAL + 1);
  localparam int S_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int ACC_W = 2 * DW + $clog2(DIM) + 1;
  localparam int UW    = DW + 2;
  localparam logic signed [UW-1:0] W_MAX = UW'((2 ** (DW - 1)) - 1);
  localparam logic signed [UW-1:0] W_MIN = UW'(-(2 ** (DW - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_ACT, S_UPD, S_EPOCH_END, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0]    w_q [DIM];
  logic signed [DW-1:0]    w_d [DIM];
  logic signed [DW-1:0]    x_q [N_SAMPLES][DIM];
  logic signed [DW-1:0]    x_d [N_SAMPLES][DIM];
  logic [N_SAMPLES-1:0]    y_q, y_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [S_W-1:0]          s_q, s_d;
  logic [SEL_W-1:0]        d_q, d_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [1:0]       delta_q, delta_d;
  logic [7:0]              run_err_q, run_err_d;
  logic [7:0]              epoch_q, epoch_d;
  logic [7:0]              err_q, err_d;
  logic                    conv_q, conv_d;

  logic                    idle_or_done, loaded, start_ok, restart_ok, word_ok;
  logic                    d_last, s_last, act;
  logic signed [DW-1:0]    x_cur, w_cur;
  logic signed [2*DW-1:0]  prod;
  logic signed [UW-1:0]    upd_sum;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign loaded       = (ptr_q == PTR_W'(TOTAL));
  assign restart_ok   = idle_or_done && load_restart;
  assign start_ok     = idle_or_done && loaded && start;
  // A restart in the same cycle drops the word.
  assign word_ok      = load_valid && load_ready && !load_restart;
  assign d_last       = (d_q == SEL_W'(DIM - 1));
  assign s_last       = (s_q == S_W'(N_SAMPLES - 1));

  // Shared datapath: the same operand pair drives the MAC product and the update.
  assign x_cur = x_q[s_q][d_q];
  assign w_cur = w_q[d_q];
  assign prod  = x_cur * w_cur;
  // Step activation: strictly positive sum fires.
  assign act   = !acc_q[ACC_W-1] && (acc_q != '0);

  // delta is restricted to {-1,0,+1}, so the update is an add/subtract of x.
  always_comb begin
    upd_sum = UW'(w_cur);
    if (delta_q == 2'sb01)      upd_sum = UW'(w_cur) + UW'(x_cur);
    else if (delta_q == 2'sb11) upd_sum = UW'(w_cur) - UW'(x_cur);
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: state and all data flops use non-blocking assignments, so every flop samples the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= S_IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_MAC;
      S_MAC:          if (d_last) state_d = S_ACT;
      S_ACT:          state_d = S_UPD;
      S_UPD:          if (d_last) state_d = s_last ? S_EPOCH_END : S_MAC;
      S_EPOCH_END: begin
        if (run_err_q == '0 || (epoch_q + 8'd1) == 8'(MAX_EPOCHS)) state_d = S_DONE;
        else                                                        state_d = S_MAC;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = !idle_or_done;
    done       = (state_q == S_DONE);
    load_ready = ena && idle_or_done && (ptr_q < PTR_W'(TOTAL));
  end

  // ------------------------------------------------------------ datapath
  // NOTE: every _d starts as a copy of its _q, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_d       = w_q;
    x_d       = x_q;
    y_d       = y_q;
    ptr_d     = ptr_q;
    s_d       = s_q;
    d_d       = d_q;
    acc_d     = acc_q;
    delta_d   = delta_q;
    run_err_d = run_err_q;
    epoch_d   = epoch_q;
    err_d     = err_q;
    conv_d    = conv_q;

    if (restart_ok) begin
      ptr_d = '0;
    end else if (word_ok) begin
      ptr_d = ptr_q + 1'b1;
      for (int i = 0; i < DIM; i++)
        if (ptr_q == PTR_W'(i)) w_d[i] = load_data;
      for (int s = 0; s < N_SAMPLES; s++) begin
        for (int j = 0; j < DIM; j++)
          if (ptr_q == PTR_W'(DIM + s * (DIM + 1) + j)) x_d[s][j] = load_data;
        if (ptr_q == PTR_W'(DIM + s * (DIM + 1) + DIM)) y_d[s] = load_data[0];
      end
    end

    if (start_ok) begin
      s_d       = '0;
      d_d       = '0;
      run_err_d = '0;
      epoch_d   = '0;
      err_d     = '0;
      conv_d    = 1'b0;
    end

    unique case (state_q)
      S_MAC: begin
        acc_d = (d_q == '0) ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        d_d   = d_last ? '0 : d_q + 1'b1;
      end
      S_ACT: begin
        delta_d = 2'sb00;
        if (y_q[s_q] && !act)      delta_d = 2'sb01;
        else if (!y_q[s_q] && act) delta_d = 2'sb11;
        if ((y_q[s_q] != act) && (run_err_q != 8'hFF)) run_err_d = run_err_q + 8'd1;
      end
      S_UPD: begin
        if (upd_sum > W_MAX)      w_d[d_q] = DW'(W_MAX);
        else if (upd_sum < W_MIN) w_d[d_q] = DW'(W_MIN);
        else                      w_d[d_q] = DW'(upd_sum);
        d_d = d_last ? '0 : d_q + 1'b1;
        if (d_last) s_d = s_last ? '0 : s_q + 1'b1;
      end
      S_EPOCH_END: begin
        epoch_d   = epoch_q + 8'd1;
        err_d     = run_err_q;
        run_err_d = '0;
        conv_d    = (run_err_q == '0);
      end
      default: ;
    endcase
  end

  // NOTE: the W/X/Y store is reset on purpose, because reset must clear the weights. These stay flops and cannot become a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) w_q[i] <= '0;
      for (int s = 0; s < N_SAMPLES; s++)
        for (int j = 0; j < DIM; j++) x_q[s][j] <= '0;
      y_q       <= '0;
      ptr_q     <= '0;
      s_q       <= '0;
      d_q       <= '0;
      acc_q     <= '0;
      delta_q   <= '0;
      run_err_q <= '0;
      epoch_q   <= '0;
      err_q     <= '0;
      conv_q    <= 1'b0;
    end else if (ena) begin
      w_q       <= w_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ptr_q     <= ptr_d;
      s_q       <= s_d;
      d_q       <= d_d;
      acc_q     <= acc_d;
      delta_q   <= delta_d;
      run_err_q <= run_err_d;
      epoch_q   <= epoch_d;
      err_q     <= err_d;
      conv_q    <= conv_d;
    end
  end

  assign converged = conv_q;
  assign epoch_cnt = epoch_q;
  assign err_cnt   = err_q;
  assign w_out     = (int'(w_sel) < DIM) ? w_q[w_sel] : '0;

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Testbench for perceptron_train_sequencer. The bench contains a table of
// known training sets with their expected results, a random set of training
// runs checked against an arithmetic reference model, and hand-written
// sequences for the load handshake, the enable stall and mid-run reset.
module tb_perceptron_train_sequencer;

  localparam int N_SAMPLES  = 3;
  localparam int DIM        = 2;
  localparam int DW         = 8;
  localparam int MAX_EPOCHS = 15;
  localparam int TOTAL      = DIM + N_SAMPLES * (DIM + 1);

  typedef logic [TOTAL*DW-1:0] words_t;

  typedef struct {
    words_t words;
    int     e1_err, e1_w0, e1_w1;
    int     epochs, err, conv, w0, w1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, ena, load_valid, load_ready, load_restart, start;
  logic          busy, done, converged;
  logic [DW-1:0] load_data;
  logic [7:0]    epoch_cnt, err_cnt;
  logic [0:0]    w_sel;
  logic [DW-1:0] w_out;

  int n_vec  = 0;
  int n_miss = 0;

  perceptron_train_sequencer #(
    .N_SAMPLES(N_SAMPLES), .DIM(DIM), .DW(DW), .MAX_EPOCHS(MAX_EPOCHS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_restart(load_restart), .start(start),
    .busy(busy), .done(done), .converged(converged),
    .epoch_cnt(epoch_cnt), .err_cnt(err_cnt),
    .w_sel(w_sel), .w_out(w_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic words_t pack(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9, v10);
    int     v [TOTAL];
    words_t r;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9, v10};
    for (int k = 0; k < TOTAL; k++) r[k*DW +: DW] = DW'(v[k]);
    return r;
  endfunction

  function automatic int word_s(input words_t w, input int k);
    logic signed [DW-1:0] b;
    b = w[k*DW +: DW];
    return int'(b);
  endfunction

  function automatic int clamp(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model: plain perceptron training on integers.
  function automatic vec_t model(input words_t words);
    vec_t r;
    int   w [DIM];
    int   x [N_SAMPLES][DIM];
    int   y [N_SAMPLES];
    int   dot, a, delta, errs, ep;
    for (int d = 0; d < DIM; d++) w[d] = word_s(words, d);
    for (int s = 0; s < N_SAMPLES; s++) begin
      for (int d = 0; d < DIM; d++) x[s][d] = word_s(words, DIM + s * (DIM + 1) + d);
      y[s] = word_s(words, DIM + s * (DIM + 1) + DIM) & 1;
    end
    r.words = words;
    ep = 0;
    r.e1_err = 0; r.e1_w0 = 0; r.e1_w1 = 0;
    do begin
      errs = 0;
      for (int s = 0; s < N_SAMPLES; s++) begin
        dot = 0;
        for (int d = 0; d < DIM; d++) dot += x[s][d] * w[d];
        a = (dot > 0) ? 1 : 0;
        delta = y[s] - a;
        if (delta != 0) errs++;
        for (int d = 0; d < DIM; d++) w[d] = clamp(w[d] + delta * x[s][d]);
      end
      ep++;
      if (ep == 1) begin
        r.e1_err = errs; r.e1_w0 = w[0]; r.e1_w1 = w[1];
      end
    end while (errs != 0 && ep < MAX_EPOCHS);
    r.epochs = ep;
    r.err    = errs;
    r.conv   = (errs == 0) ? 1 : 0;
    r.w0     = w[0];
    r.w1     = w[1];
    return r;
  endfunction

  task automatic read_w(output int w0, output int w1);
    w_sel = 1'b0;
    #1 w0 = int'($signed(w_out));
    w_sel = 1'b1;
    #1 w1 = int'($signed(w_out));
  endtask

  // Rewind with a junk word that must be dropped, then stream n words.
  task automatic load_set(input words_t words, input int n);
    @(negedge clk);
    load_restart = 1'b1; load_valid = 1'b1; load_data = 8'h55;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      load_restart = 1'b0; load_valid = 1'b1; load_data = words[k*DW +: DW];
    end
    @(negedge clk);
    load_valid = 1'b0; load_restart = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 4000) begin
      @(negedge clk);
      c++;
    end
  endtask

  // cyc counts the start-accept edge as 1. It is sampled on the negedge.
  task automatic run(input int stall_at, input int stall_len, input int pulse_at,
                     output int cyc, output int e1e, output int e1w0, output int e1w1);
    int cap;
    cap  = 17 + ((stall_at > 0 && stall_at < 17) ? stall_len : 0);
    e1e  = -999; e1w0 = -999; e1w1 = -999;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    forever begin
      if (cyc == cap) begin
        e1e = int'(err_cnt);
        read_w(e1w0, e1w1);
      end
      if (done || cyc >= 4000) break;
      if (cyc == stall_at) ena = 1'b0;
      if (cyc == stall_at + stall_len) ena = 1'b1;
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    ena = 1'b1; start = 1'b0;
  endtask

  task automatic check_run(input string tag, input vec_t v, input int extra,
                           input int cyc, input int e1e, input int e1w0, input int e1w1);
    int w0, w1;
    read_w(w0, w1);
    check({tag, " cycles"}, cyc, 16 * v.epochs + 1 + extra);
    check({tag, " converged"}, converged, v.conv);
    check({tag, " epoch_cnt"}, epoch_cnt, v.epochs);
    check({tag, " err_cnt"}, err_cnt, v.err);
    check({tag, " w0"}, w0, v.w0);
    check({tag, " w1"}, w1, v.w1);
    check({tag, " e1_err"}, e1e, v.e1_err);
    check({tag, " e1_w0"}, e1w0, v.e1_w0);
    check({tag, " e1_w1"}, e1w1, v.e1_w1);
  endtask

  vec_t tbl [3];

  initial begin
    int     cyc, e1e, e1w0, e1w1, w0, w1;
    vec_t   ref_v;
    words_t rw;

    tbl[0] = '{words: pack(0, 0, 1, 0, 1, 0, 1, 0, 2, 1, 1),
               e1_err: 1, e1_w0: 1, e1_w1: 0, epochs: 2, err: 0, conv: 1, w0: 1, w1: 0};
    tbl[1] = '{words: pack(4, 9, 2, 3, 0, 4, 5, 1, 1, 2, 1),
               e1_err: 1, e1_w0: 2, e1_w1: 6, epochs: 15, err: 2, conv: 0, w0: 3, w1: 1};
    tbl[2] = '{words: pack(120, -128, 10, 10, 1, 10, 10, 1, 10, 10, 1),
               e1_err: 1, e1_w0: 127, e1_w1: -118, epochs: 2, err: 0, conv: 1, w0: 127, w1: -118};

    rst_n = 1'b0; ena = 1'b1; load_valid = 1'b0; load_restart = 1'b0;
    start = 1'b0; load_data = '0; w_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_w(w0, w1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset converged", converged, 0);
    check("reset epoch_cnt", epoch_cnt, 0);
    check("reset err_cnt", err_cnt, 0);
    check("reset load_ready", load_ready, 1);
    check("reset w0", w0, 0);
    check("reset w1", w1, 0);

    // Known training sets.
    for (int i = 0; i < 3; i++) begin
      load_set(tbl[i].words, TOTAL);
      run(0, 0, 0, cyc, e1e, e1w0, e1w1);
      check_run($sformatf("tbl%0d", i), tbl[i], 0, cyc, e1e, e1w0, e1w1);
    end

    // Random sets: odd iterations use small values that often converge.
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < TOTAL; k++) begin
        int v;
        v = (it % 2 == 1) ? int'($urandom_range(0, 8)) - 4 : int'($urandom_range(0, 255));
        rw[k*DW +: DW] = DW'(v);
      end
      ref_v = model(rw);
      load_set(rw, TOTAL);
      run(0, 0, 0, cyc, e1e, e1w0, e1w1);
      check_run($sformatf("rand%0d", it), ref_v, 0, cyc, e1e, e1w0, e1w1);
    end

    // Handshake: partial load, start ignored, full pointer, load and restart ignored while busy.
    load_set(tbl[0].words, TOTAL - 1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("hs start_unloaded busy", busy, 0);
    check("hs ready_before_last", load_ready, 1);
    load_valid = 1'b1; load_data = tbl[0].words[(TOTAL-1)*DW +: DW];
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'h7f;
    check("hs ready_full", load_ready, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; load_restart = 1'b1;
    repeat (3) @(negedge clk);
    check("hs busy_run", busy, 1);
    check("hs ready_busy", load_ready, 0);
    load_restart = 1'b0; load_valid = 1'b0;
    wait_done(cyc);
    read_w(w0, w1);
    check("hs restart_ignored ready", load_ready, 0);
    check("hs run converged", converged, 1);
    check("hs run epoch_cnt", epoch_cnt, 2);
    check("hs run w0", w0, 1);
    check("hs run w1", w1, 0);
    @(negedge clk); load_restart = 1'b1;
    @(negedge clk); load_restart = 1'b0;
    check("hs ready_after_restart", load_ready, 1);
    load_set(tbl[2].words, TOTAL);
    run(0, 0, 0, cyc, e1e, e1w0, e1w1);
    check_run("hs reload", tbl[2], 0, cyc, e1e, e1w0, e1w1);

    // Enable stall of 7 cycles plus a start pulse while busy; then rerun from trained weights.
    load_set(tbl[0].words, TOTAL);
    run(5, 7, 12, cyc, e1e, e1w0, e1w1);
    check_run("stall", tbl[0], 7, cyc, e1e, e1w0, e1w1);
    run(0, 0, 0, cyc, e1e, e1w0, e1w1);
    read_w(w0, w1);
    check("rerun cycles", cyc, 17);
    check("rerun converged", converged, 1);
    check("rerun epoch_cnt", epoch_cnt, 1);
    check("rerun err_cnt", err_cnt, 0);
    check("rerun w0", w0, 1);

    // Reset in the middle of the second epoch of the non-separable set.
    load_set(tbl[1].words, TOTAL);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst epoch_cnt", epoch_cnt, 0);
    check("midrst err_cnt", err_cnt, 0);
    check("midrst load_ready", load_ready, 1);
    read_w(w0, w1);
    check("midrst w0", w0, 0);
    check("midrst w1", w1, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("midrst start_unloaded busy", busy, 0);
    load_set(tbl[1].words, TOTAL);
    run(0, 0, 0, cyc, e1e, e1w0, e1w1);
    check_run("midrst rerun", tbl[1], 0, cyc, e1e, e1w0, e1w1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
